peripheral_bus: RTL
===================

PERIPHERAL_BUS -- requirements
Module: peripheral_bus

Interface
REQ-001 Parameter: none; the address map is fixed by the shared package constants.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 MemRead  input  1  CPU MEM-stage read strobe.
REQ-005 MemWrite  input  1  CPU MEM-stage write strobe.
REQ-006 Address  input  32  CPU MEM-stage byte address (ALU result).
REQ-007 Write_Data  input  32  CPU MEM-stage store data.
REQ-008 Read_Data  output  32  peripheral read data; the top-level mux routes it onto Device_Read_Data.
REQ-009 Periph_Hit  output  1  high when Address decodes to a mapped peripheral word; the top-level mux uses it to select this block over data memory.
REQ-010 leds  output  8  LED register contents.
REQ-011 digits  output  12  seven-segment register; [11:8] is the anode select and [7:0] the segments.
REQ-012 irq  output  1  timer interrupt request.

Function
REQ-013 Address map (word, Address[1:0]==00, full 32-bit match):
- 0x4000_0000 TH: timer reload value, R/W.
- 0x4000_0004 TL: timer counter, R/W.
- 0x4000_0008 TCON[2:0]: bit0 enable, bit1 irq-enable, bit2 status; R/W; upper bits read 0.
- 0x4000_000C LEDS[7:0]: R/W.
- 0x4000_0010 DIGITS[11:0]: R/W.
- 0x4000_0014 SYSTICK: read-only.
REQ-014 Periph_Hit is combinational: 1 only for the six addresses above; any other address, including a misaligned one, gives 0.
REQ-015 Read_Data is combinational, with zero latency within the same cycle: it equals the addressed register (zero-extended) when MemRead and Periph_Hit are both high, and 0 otherwise.
REQ-016 A write takes effect at the rising edge when MemWrite and Periph_Hit are both high; the new value is visible on Read_Data in the next cycle.
REQ-017 Writes to SYSTICK and writes to unmapped addresses are ignored, with no state change.
REQ-018 SYSTICK increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
REQ-019 While TCON[0]=1, TL increments by 1 every cycle; while TCON[0]=0, TL holds.
REQ-020 Overflow: with TCON[0]=1 and TL==0xFFFF_FFFF, the next TL is TH rather than 0, and TCON[2] is set to 1 if TCON[1]=1.
REQ-021 TCON[2] stays set (sticky) until software writes TCON.
REQ-022 irq = TCON[1] & TCON[2], combinational from the registers.
REQ-023 Simultaneous events, where a CPU write always has priority over same-cycle hardware updates:
- A TL write in the same cycle as an increment or overflow: TL takes Write_Data.
- A TCON write in the same cycle as an overflow: TCON takes Write_Data[2:0], and the overflow's status set is lost.
- A TH write in the same cycle as an overflow: TL reloads from the old TH.
REQ-024 MemRead and MemWrite both high in the same cycle: the read returns the pre-write value and the write commits at the edge.
REQ-025 Reads have no side effects; reading TCON does not clear the status bit.

Reset
REQ-026 While reset=0, all registers clear asynchronously: TH, TL, TCON, LEDS, DIGITS and SYSTICK become 0, so leds=0, digits=0 and irq=0.
REQ-027 Read_Data and Periph_Hit remain purely combinational during reset, and reads return 0.
REQ-028 A reset asserted mid-count discards the counter state immediately.
REQ-029 Counting resumes only after software sets TCON[0] again; SYSTICK restarts from 0 on the first edge after reset deasserts.

Structure
REQ-030 The shared package holds:
- the six address constants;
- the TCON bit indices (TCON_EN=0, TCON_IE=1, TCON_ST=2);
- the LEDS width (8) and DIGITS width (12).
REQ-031 TH/TL/TCON, with the increment, reload and status logic, live in one sub-module, timer_core, which receives decoded write enables from peripheral_bus.
REQ-032 peripheral_bus contains the address decoder, the LEDS, DIGITS and SYSTICK registers, and the read mux.

Verification
REQ-033 Reset deasserted, then MemRead at 0x4000_0014 on cycles 0 and 10 -> Read_Data reads differ by exactly 10.
REQ-034 Write TH=0xFFFF_FFF0, write TL=0xFFFF_FFFE, write TCON=3 -> TL reads 0xFFFF_FFFF one cycle later and 0xFFFF_FFF0 the cycle after; TCON reads 7 and irq=1.
REQ-035 With irq=1, write TCON=3 -> irq=0 in the next cycle, and TL keeps counting from its current value.
REQ-036 TL write of 0x1234 in the same cycle as an overflow -> TL=0x1234, then 0x1235 in the following cycle.
REQ-037 Write LEDS=0xA5 and DIGITS=0x8F3 -> leds=0xA5 and digits=0x8F3; a read at 0x4000_0018 or 0x4000_0001 -> Periph_Hit=0 and Read_Data=0.
REQ-038 reset=0 pulsed asynchronously between clock edges while the timer runs -> all outputs 0 immediately, and TL holds at 0 after release.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// Shared constants for the memory-mapped peripheral block.
// Holds the fixed word address map, the TCON bit positions and the
// widths of the LEDS and DIGITS registers.
package peripheral_bus_pkg;

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LEDS    = 32'h4000_000C;
    localparam logic [31:0] ADDR_DIGITS  = 32'h4000_0010;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;
    localparam int TCON_W  = 3;

    localparam int LEDS_W   = 8;
    localparam int DIGITS_W = 12;

endpackage

// File: rtl/peripheral_bus_timer_core.sv
// Reloadable 32-bit timer: TH (reload), TL (counter), TCON (control/status).
// Ports:
//   clk, reset    - clock, async active-low reset
//   th_we/tl_we/tcon_we - decoded write enables from the bus
//   wdata         - store data
//   th, tl, tcon  - register contents for the read mux
//   irq           - TCON.IE & TCON.ST
module timer_core
    import peripheral_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              th_we,
    input  logic              tl_we,
    input  logic              tcon_we,
    input  logic [31:0]       wdata,
    output logic [31:0]       th,
    output logic [31:0]       tl,
    output logic [TCON_W-1:0] tcon,
    output logic              irq
);

    logic ovf;

    assign ovf = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
    assign irq = tcon[TCON_IE] & tcon[TCON_ST];

    // CPU writes override same-cycle hardware updates. The reload reads
    // the registered (old) TH, so a TH write during overflow does not
    // affect the value loaded this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (th_we)
                th <= wdata;

            if (tl_we)
                tl <= wdata;
            else if (ovf)
                tl <= th;
            else if (tcon[TCON_EN])
                tl <= tl + 32'd1;

            // Status is sticky; only a software TCON write clears it.
            if (tcon_we)
                tcon <= wdata[TCON_W-1:0];
            else if (ovf && tcon[TCON_IE])
                tcon[TCON_ST] <= 1'b1;
        end
    end

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral block on the CPU MEM stage.
// Decodes the fixed address map, holds LEDS, DIGITS and SYSTICK, hosts the
// timer and drives a zero-latency combinational read mux.
// Ports:
//   clk, reset          - clock, async active-low reset
//   MemRead, MemWrite   - MEM-stage strobes
//   Address, Write_Data - byte address and store data
//   Read_Data           - addressed register when MemRead & Periph_Hit, else 0
//   Periph_Hit          - Address matches one of the six mapped words
//   leds, digits, irq   - LED register, seven-segment register, timer irq
module peripheral_bus
    import peripheral_bus_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [31:0]         Address,
    input  logic [31:0]         Write_Data,
    output logic [31:0]         Read_Data,
    output logic                Periph_Hit,
    output logic [LEDS_W-1:0]   leds,
    output logic [DIGITS_W-1:0] digits,
    output logic                irq
);

    logic sel_th, sel_tl, sel_tcon, sel_leds, sel_digits, sel_sys;
    logic [31:0]       th, tl, systick;
    logic [TCON_W-1:0] tcon;

    // Full 32-bit compare, so misaligned or aliased addresses never hit.
    assign sel_th     = (Address == ADDR_TH);
    assign sel_tl     = (Address == ADDR_TL);
    assign sel_tcon   = (Address == ADDR_TCON);
    assign sel_leds   = (Address == ADDR_LEDS);
    assign sel_digits = (Address == ADDR_DIGITS);
    assign sel_sys    = (Address == ADDR_SYSTICK);

    assign Periph_Hit = sel_th | sel_tl | sel_tcon | sel_leds | sel_digits | sel_sys;

    timer_core u_timer (
        .clk     (clk),
        .reset   (reset),
        .th_we   (MemWrite & sel_th),
        .tl_we   (MemWrite & sel_tl),
        .tcon_we (MemWrite & sel_tcon),
        .wdata   (Write_Data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    // SYSTICK is read-only: it has no write path at all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds    <= '0;
            digits  <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (MemWrite && sel_leds)
                leds <= Write_Data[LEDS_W-1:0];
            if (MemWrite && sel_digits)
                digits <= Write_Data[DIGITS_W-1:0];
        end
    end

    // Reads see pre-edge register values, so a same-cycle read/write
    // returns the old contents.
    always_comb begin
        Read_Data = 32'h0;
        if (MemRead) begin
            if (sel_th)     Read_Data = th;
            if (sel_tl)     Read_Data = tl;
            if (sel_tcon)   Read_Data = 32'(tcon);
            if (sel_leds)   Read_Data = 32'(leds);
            if (sel_digits) Read_Data = 32'(digits);
            if (sel_sys)    Read_Data = systick;
        end
    end

endmodule
